// File: rtl/memoria_sync.sv
// memoria_sync: clocked single-port data memory with a self-initialising boot sweep
module memoria_sync #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 16,
  parameter int INIT_COUNT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] adress,
  input  logic [DATA_W-1:0] inDataBus,
  output logic [DATA_W-1:0] outDataBus,
  output logic              valid,
  output logic              busy
);
  typedef enum logic {INIT, IDLE} state_t;
  localparam logic [ADDR_W:0]   D    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   IC   = (ADDR_W+1)'(INIT_COUNT);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  state_t            state, state_nx;
  logic [ADDR_W-1:0] init_ptr, ptr_nx;
  logic [DATA_W-1:0] memory [DEPTH];
  logic [DATA_W-1:0] init_val, out_nx;
  logic              in_range, accept;
  always_comb begin
    in_range = {1'b0, adress} < D;
    init_val = ({1'b0, init_ptr} < IC) ? DATA_W'(init_ptr) + ONE : '0;
    accept   = (state == IDLE) && rd;
    ptr_nx   = (state == INIT) ? init_ptr + ADDR_W'(1) : init_ptr;
    state_nx = (state == INIT && init_ptr == LAST) ? IDLE : state;
    out_nx   = accept ? (in_range ? memory[adress] : '0) : outDataBus;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      init_ptr   <= '0;
      outDataBus <= '0;
      valid      <= 1'b0;
      busy       <= 1'b1;
    end else begin
      state      <= state_nx;
      init_ptr   <= ptr_nx;
      outDataBus <= out_nx;
      valid      <= accept;
      busy       <= (state_nx == INIT);
    end
  end
  // array has no reset: the sweep rewrites every word after each reset
  always_ff @(posedge clk) begin
    if (state == INIT)
      memory[init_ptr] <= init_val;
    else if (wr && in_range)
      memory[adress] <= inDataBus;
  end
endmodule

// File: doc/memoria_sync.md
# memoria_sync

Parametrised synchronous single-port data memory for the CPU datapath. Replaces the 16×8 level-sensitive memory with a clocked array of configurable width and depth. After reset it runs a self-initialisation sweep that clears the array and loads the boot constants. It then serves one read or write per cycle, with registered read data and a valid strobe.

## Interface
- `DATA_W`, 8: data bus width in bits.
- `ADDR_W`, 4: address width in bits.
- `DEPTH`, 16: number of words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W.
- `INIT_COUNT`, 5: number of preloaded words; location i < INIT_COUNT loads i+1, every other location loads 0; must be ≤ DEPTH.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `rd`, input, 1: read request, sampled at the clock edge.
- `wr`, input, 1: write request, sampled at the clock edge.
- `adress`, input, ADDR_W: word address.
- `inDataBus`, input, DATA_W: write data.
- `outDataBus`, output, DATA_W: registered read data.
- `valid`, output, 1: one-cycle pulse marking new data on `outDataBus`.
- `busy`, output, 1: high during the init sweep; requests are ignored while high.

## Operation
- The FSM has two states:
  - INIT: a counter `init_ptr` (ADDR_W bits) sweeps from 0 to DEPTH-1. Each edge writes the init value to `memory[init_ptr]` and increments the pointer. After the edge that writes DEPTH-1, the FSM moves to IDLE.
  - IDLE: serves requests and stays in IDLE until reset.
- Reset values:
  - State = INIT, `init_ptr` = 0.
  - `outDataBus` = 0, `valid` = 0, `busy` = 1.
  - The array contents are not reset directly; the sweep rewrites them.
- Reset asserted mid-sweep or mid-operation: state, pointer and outputs return immediately to their reset values, and the sweep restarts from location 0 after release.
- Write in IDLE with `wr`=1 and `adress` < DEPTH: `memory[adress]` ← `inDataBus` at that edge.
- Read in IDLE with `rd`=1: `outDataBus` ← `memory[adress]` and `valid` ← 1 at that edge.
  - Otherwise `valid` ← 0 and `outDataBus` holds its last value.
- `rd` and `wr` together at the same address is read-before-write: `outDataBus` gets the old contents, and the array stores the new data.
- Out-of-range address (`adress` ≥ DEPTH, possible only when DEPTH < 2^ADDR_W):
  - A write is dropped; no array location changes.
  - A read returns 0 with `valid`=1.
- Requests presented while `busy`=1 are discarded: no write, no `valid`, and they are not queued.
- `busy` is a registered output: 1 in INIT, 0 in IDLE.

## Timing
- The sweep takes exactly DEPTH rising edges after `rst_n` rises. Counting edges from 1, edge k writes location k-1, and `busy` falls after edge DEPTH.
- The first request that can be accepted is sampled on edge DEPTH+1.
- Read latency is 1 cycle: a request sampled at edge n gives data and `valid`=1 in the cycle after edge n, and `valid` falls after edge n+1 unless `rd` is held.
- Back-to-back reads are supported. Holding `rd` for N edges gives N consecutive `valid` cycles, one word per cycle.
- Write latency is 1 edge: a read of the same address on the next edge returns the new data.
- There is no stall or backpressure in IDLE; throughput is 1 access per cycle.

## Test plan
- Reset/init, with defaults: release `rst_n` and check that `busy` = 1 for 16 edges and then falls. Then read addresses 0–5 on consecutive edges and check `outDataBus` = 1, 2, 3, 4, 5, 0, with `valid` high each cycle.
- Write then read:
  - Write 0xA5 to address 9 at edge n, read address 9 at edge n+1: check `outDataBus` = 0xA5 and `valid`=1 after edge n+1.
  - Check that `outDataBus` then holds 0xA5 with `valid`=0 while idle.
- Simultaneous access: with address 2 holding 3, assert `rd`=`wr`=1 with `inDataBus`=0x7E. Check `outDataBus` = 0x03, then on a following read of address 2 check 0x7E.
- Requests during `busy`: during the sweep, assert `wr` to address 3 with 0xFF and assert `rd`. Check `valid` stays 0, and after init check that address 3 reads 4.
- Reset mid-operation:
  - Write 0x55 to address 12, assert `rst_n`=0 for one cycle asynchronously between edges. Check outputs go to 0 and `busy` to 1 immediately.
  - After a 16-edge sweep, check that address 12 reads 0.
  - Repeat with reset asserted at edge 7 of the sweep and check the sweep restarts and lasts a full 16 edges.
- Out-of-range access, with DEPTH=12 and ADDR_W=4:
  - Check the sweep lasts 12 edges.
  - Write 0x33 to address 14 and read address 14: check 0 with `valid`=1.
  - Check that addresses 0–11 are unchanged.
